// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: instruction-fetch front end. Holds the PC, issues one-outstanding
// fetches to instruction memory, buffers the returned word for decode and applies
// branch/jump redirects.
//
// Ports
//   clk_i, rstn_i            rising-edge clock, synchronous active-low reset
//   redirect_pc_i            address of the branch/jump instruction causing a redirect
//   branch_taken_i           take branch, target = redirect_pc + 4 + imm_sl2 (wins over jump)
//   imm_sl2_i                sign-extended branch offset already scaled by 4
//   jump_i                   take jump, target = {(redirect_pc + 4)[n-1:28], jump_index, 2'b00}
//   jump_index_i             26-bit jump instruction index
//   imem_req_o, imem_ready_i fetch request handshake; imem_addr_o always carries the PC
//   imem_rvalid_i, imem_rdata_i  exactly one response per accepted request
//   instr_valid_o, instr_ready_i decode handshake for instr_o fetched from instr_pc_o
module fetch_pc_unit #(
    parameter int unsigned  n        = 32,
    parameter logic [n-1:0] RESET_PC = '0
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic [n-1:0] redirect_pc_i,
    input  logic         branch_taken_i,
    input  logic [n-1:0] imm_sl2_i,
    input  logic         jump_i,
    input  logic [25:0]  jump_index_i,
    output logic         imem_req_o,
    output logic [n-1:0] imem_addr_o,
    input  logic         imem_ready_i,
    input  logic         imem_rvalid_i,
    input  logic [31:0]  imem_rdata_i,
    output logic         instr_valid_o,
    output logic [31:0]  instr_o,
    output logic [n-1:0] instr_pc_o,
    input  logic         instr_ready_i
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_e;

    state_e       state_q;
    logic [n-1:0] pc_q, pc_d, pend_q, instr_pc_q, seq_pc, br_tgt, jmp_tgt;
    logic [31:0]  instr_q;
    logic         drop_q, req_q, valid_q, redir, acc, busy;

    assign seq_pc = redirect_pc_i + n'(4);
    assign br_tgt = seq_pc + imm_sl2_i;
    assign redir  = branch_taken_i | jump_i;
    assign acc    = req_q & imem_ready_i;
    // A response is still owed by memory: either the live fetch or a stale one.
    assign busy   = (state_q == WAIT) | drop_q;

    always_comb begin
        jmp_tgt = seq_pc;
        jmp_tgt[27:0] = {jump_index_i, 2'b00};
    end

    // Redirect overrides the sequential +4 step taken on an accepted fetch.
    assign pc_d = redir ? (branch_taken_i ? br_tgt : jmp_tgt) : acc ? pc_q + n'(4) : pc_q;

    // req_q/valid_q mirror (state == REQ && !drop) and (state == HOLD) as flops,
    // so neither handshake output has a combinational path from any input.
    // drop also gates the request: while a stale response is owed no new fetch
    // may be issued, which keeps memory strictly one-outstanding after reset.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
            instr_q    <= '0;
            instr_pc_q <= '0;
            // Remember a response that is still in flight across reset so it is discarded.
            drop_q     <= (busy & ~imem_rvalid_i) | acc;
        end else begin
            pc_q <= pc_d;
            if (drop_q && imem_rvalid_i)
                drop_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    state_q <= REQ;
                    req_q   <= ~(drop_q & ~imem_rvalid_i);
                end
                REQ: begin
                    if (acc) begin
                        pend_q  <= pc_q;
                        state_q <= WAIT;
                        req_q   <= 1'b0;
                        drop_q  <= redir;
                    end else begin
                        req_q <= ~(drop_q & ~imem_rvalid_i);
                    end
                end
                WAIT: begin
                    if (imem_rvalid_i) begin
                        drop_q <= 1'b0;
                        // A redirect in the arrival cycle kills the word just like drop.
                        if (drop_q || redir) begin
                            state_q <= REQ;
                            req_q   <= 1'b1;
                        end else begin
                            instr_q    <= imem_rdata_i;
                            instr_pc_q <= pend_q;
                            state_q    <= HOLD;
                            valid_q    <= 1'b1;
                        end
                    end else if (redir) begin
                        drop_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (redir || instr_ready_i) begin
                        state_q <= REQ;
                        req_q   <= 1'b1;
                        valid_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign imem_req_o    = req_q;
    assign imem_addr_o   = pc_q;
    assign instr_valid_o = valid_q;
    assign instr_o       = instr_q;
    assign instr_pc_o    = instr_pc_q;
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: randomized self-checking bench for fetch_pc_unit with a
// transaction-level reference model and a reactive instruction-memory model.
`timescale 1ns/1ps
module tb_fetch_pc_unit;
    localparam logic [31:0] RPC = 32'hFFFF_FFFC;

    logic        clk = 1'b0, rstn = 1'b0;
    logic [31:0] redirect_pc = '0, imm_sl2 = '0, imem_rdata = '0;
    logic [31:0] imem_addr, instr, instr_pc;
    logic        branch_taken = 1'b0, jump = 1'b0, imem_ready = 1'b0, imem_rvalid = 1'b0, instr_ready = 1'b0;
    logic        imem_req, instr_valid;
    logic [25:0] jump_index = '0;

    int tests = 0, fails = 0;

    // memory model: one pending response with a countdown
    bit          mem_busy = 0;
    int          mem_cnt = 0, mem_delay = 0;
    logic [31:0] mem_addr = '0;

    // reference model: pc, boot cycle, outstanding fetch and decode buffer
    logic [31:0] m_pc = RPC, m_oaddr = '0, m_bd = '0, m_bpc = '0;
    bit          m_boot = 1, m_out = 0, m_stale = 0, m_bv = 0;

    logic [31:0] acc_q[$];
    logic [31:0] pres_q[$];

    always #5 clk = ~clk;

    fetch_pc_unit #(.n(32), .RESET_PC(RPC)) dut (
        .clk_i(clk), .rstn_i(rstn),
        .redirect_pc_i(redirect_pc), .branch_taken_i(branch_taken), .imm_sl2_i(imm_sl2),
        .jump_i(jump), .jump_index_i(jump_index),
        .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_ready_i(imem_ready),
        .imem_rvalid_i(imem_rvalid), .imem_rdata_i(imem_rdata),
        .instr_valid_o(instr_valid), .instr_o(instr), .instr_pc_o(instr_pc),
        .instr_ready_i(instr_ready)
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_acc(input string name, input int idx, input logic [31:0] exp);
        if (idx < acc_q.size()) chk(name, acc_q[idx], exp);
        else begin
            tests++; fails++;
            $display("FAIL %s: only %0d fetches accepted, expected %h at index %0d", name, acc_q.size(), exp, idx);
        end
    endtask

    // Compare every DUT output the model defines for the current cycle.
    task automatic check();
        chk("imem_req", 32'(imem_req), 32'(!m_boot && !m_out && !m_bv));
        chk("imem_addr", imem_addr, m_pc);
        chk("instr_valid", 32'(instr_valid), 32'(m_bv));
        if (m_bv) begin
            chk("instr", instr, m_bd);
            chk("instr_pc", instr_pc, m_bpc);
        end
    endtask

    // One clock: memory reacts, model advances on the same inputs, then outputs are checked.
    task automatic cycle();
        logic [31:0] seq, tgt;
        bit redir, acc_m;
        imem_rvalid = mem_busy && mem_cnt == 0;
        imem_rdata  = imem_rvalid ? memf(mem_addr) : 32'hDEAD_BEEF;
        if (mem_busy) begin
            if (mem_cnt == 0) mem_busy = 0;
            else mem_cnt--;
        end
        if (imem_req === 1'b1 && imem_ready) begin
            mem_busy = 1;
            mem_addr = imem_addr;
            mem_cnt  = mem_delay < 0 ? int'($urandom_range(0, 3)) : mem_delay;
            if (rstn) acc_q.push_back(imem_addr);
        end
        if (instr_valid === 1'b1 && instr_ready && rstn) pres_q.push_back(instr_pc);
        seq   = redirect_pc + 32'd4;
        tgt   = branch_taken ? seq + imm_sl2 : {seq[31:28], jump_index, 2'b00};
        redir = branch_taken || jump;
        acc_m = !m_boot && !m_out && !m_bv && imem_ready;
        if (!rstn) begin
            m_out   = (m_out && !imem_rvalid) || acc_m;
            m_stale = m_out;
            m_pc    = RPC;
            m_boot  = 1;
            m_bv    = 0;
            m_bd    = '0;
            m_bpc   = '0;
        end else begin
            if (m_bv && (instr_ready || redir)) m_bv = 0;
            if (m_out && imem_rvalid) begin
                m_out = 0;
                if (!m_stale && !redir) begin
                    m_bv  = 1;
                    m_bd  = memf(m_oaddr);
                    m_bpc = m_oaddr;
                end
                m_stale = 0;
            end else if (m_out && redir) begin
                m_stale = 1;
            end
            if (acc_m) begin
                m_out   = 1;
                m_stale = redir;
                m_oaddr = m_pc;
            end
            m_pc   = redir ? tgt : acc_m ? m_pc + 32'd4 : m_pc;
            m_boot = 0;
        end
        @(posedge clk);
        #1;
        check();
    endtask

    task automatic wait_valid(input string name, input int budget);
        int k = 0;
        while (instr_valid !== 1'b1 && k < budget) begin cycle(); k++; end
        if (instr_valid !== 1'b1) begin
            tests++; fails++;
            $display("FAIL %s: instr_valid not seen within %0d cycles", name, budget);
        end
    endtask

    task automatic wait_acc(input string name, input int n0, input int budget);
        int k = 0;
        while (acc_q.size() <= n0 && k < budget) begin cycle(); k++; end
        if (acc_q.size() <= n0) begin
            tests++; fails++;
            $display("FAIL %s: no fetch accepted within %0d cycles", name, budget);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int pb, n0;
        logic [31:0] i0, p0;
        // reset state
        imem_ready = 1; instr_ready = 1; mem_delay = 0;
        cycle(); cycle();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, RPC);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_instr_pc", instr_pc, 32'd0);
        // best-case latency and sequential fetch with wrap
        rstn = 1;
        cycle();
        chk("first_req", 32'(imem_req), 32'd1);
        chk("first_addr", imem_addr, RPC);
        cycle();
        chk("wait_no_req", 32'(imem_req), 32'd0);
        cycle();
        chk("first_valid", 32'(instr_valid), 32'd1);
        chk("first_instr_pc", instr_pc, RPC);
        chk("first_instr", instr, memf(RPC));
        repeat (9) cycle();
        chk_acc("seq_fetch0", 0, RPC);
        chk_acc("seq_fetch1_wrap", 1, 32'h0000_0000);
        chk_acc("seq_fetch2", 2, 32'h0000_0004);
        chk_acc("seq_fetch3", 3, 32'h0000_0008);
        // branch in HOLD with a same-cycle consume
        wait_valid("hold_before_branch", 20);
        pb = pres_q.size();
        redirect_pc = 32'h10; imm_sl2 = 32'h20; branch_taken = 1;
        cycle();
        branch_taken = 0;
        chk("br_hold_consumed", 32'(pres_q.size()), 32'(pb + 1));
        chk("br_hold_invalid", 32'(instr_valid), 32'd0);
        chk("br_hold_addr", imem_addr, 32'h34);
        chk("br_hold_req", 32'(imem_req), 32'd1);
        // negative branch offset while a request waits for memory
        imem_ready = 0;
        redirect_pc = 32'h10; imm_sl2 = 32'hFFFF_FFF0; branch_taken = 1;
        cycle();
        branch_taken = 0;
        chk("br_neg_addr", imem_addr, 32'h04);
        // jump, then branch and jump together
        redirect_pc = 32'h1000_0000; jump_index = 26'h100; jump = 1;
        cycle();
        chk("jump_addr", imem_addr, 32'h1000_0400);
        redirect_pc = 32'h10; imm_sl2 = 32'h20; branch_taken = 1;
        cycle();
        jump = 0; branch_taken = 0;
        chk("br_over_jump_addr", imem_addr, 32'h34);
        // redirect while waiting on a slow response
        imem_ready = 1; mem_delay = 3;
        cycle();
        chk("slow_accepted", acc_q[acc_q.size() - 1], 32'h34);
        redirect_pc = 32'h100; imm_sl2 = 32'h40; branch_taken = 1;
        cycle();
        branch_taken = 0;
        chk("wait_redir_addr", imem_addr, 32'h144);
        n0 = acc_q.size();
        wait_acc("wait_redir_refetch", n0, 20);
        chk_acc("wait_redir_fetch", n0, 32'h144);
        wait_valid("wait_redir_data", 20);
        chk("wait_redir_instr_pc", instr_pc, 32'h144);
        chk("wait_redir_instr", instr, memf(32'h144));
        // decode stall in HOLD
        instr_ready = 0; i0 = instr; p0 = instr_pc;
        repeat (5) begin
            cycle();
            chk("stall_instr", instr, i0);
            chk("stall_instr_pc", instr_pc, p0);
            chk("stall_no_req", 32'(imem_req), 32'd0);
        end
        // reset in WAIT with a stale response arriving afterwards
        instr_ready = 1;
        n0 = acc_q.size();
        wait_acc("pre_reset_fetch", n0, 20);
        rstn = 0;
        cycle();
        rstn = 1;
        chk("wait_rst_addr", imem_addr, RPC);
        chk("wait_rst_valid", 32'(instr_valid), 32'd0);
        n0 = acc_q.size();
        wait_acc("post_reset_fetch", n0, 20);
        chk_acc("post_reset_addr", n0, RPC);
        wait_valid("post_reset_data", 20);
        chk("post_reset_instr_pc", instr_pc, RPC);
        chk("post_reset_instr", instr, memf(RPC));
        // randomized traffic
        mem_delay = -1;
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 15));
            imem_ready   = $urandom_range(0, 3) != 0;
            instr_ready  = $urandom_range(0, 3) != 0;
            branch_taken = r == 0 || r == 2;
            jump         = r == 1 || r == 2;
            redirect_pc  = 32'($urandom);
            imm_sl2      = 32'($urandom);
            jump_index   = 26'($urandom);
            rstn         = $urandom_range(0, 199) != 0;
            cycle();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Instruction-fetch front end for the single-issue core: holds the program counter, issues one-outstanding fetch requests to instruction memory, buffers the returned word for decode, and applies redirects. Branch targets are formed from the word-aligned offset produced by the left-shift-by-2 stage (`imm_sl2`). Jump targets are formed from the 26-bit jump index. This block is the direct consumer of the shifter output and feeds decode.

## Interface
- `n`, 32, address/PC width (≥ 28)
- `RESET_PC`, 32'h00000000, PC loaded on reset
- `clk`  in  1  single clock, rising edge
- `rstn`  in  1  reset, synchronous, active-low
- `redirect_pc`  in  n  address of the branch/jump instruction causing a redirect
- `branch_taken`  in  1  take branch this cycle
- `imm_sl2`  in  n  sign-extended offset already shifted left by 2
- `jump`  in  1  take jump this cycle
- `jump_index`  in  26  jump instruction index field
- `imem_req`  out  1  fetch request valid
- `imem_addr`  out  n  fetch address (always = `pc` while `imem_req`)
- `imem_ready`  in  1  memory accepts request when `imem_req && imem_ready`
- `imem_rvalid`  in  1  read data valid (≥1 cycle after accept, exactly one per accept)
- `imem_rdata`  in  32  fetched instruction
- `instr_valid`  out  1  buffered instruction valid
- `instr`  out  32  buffered instruction
- `instr_pc`  out  n  address of `instr`
- `instr_ready`  in  1  decode consumes when `instr_valid && instr_ready`

## Operation
- States: IDLE, REQ, WAIT, HOLD. Registers: `pc`, `drop` flag, instruction buffer (`instr`, `instr_pc`).
- IDLE→REQ unconditionally (one cycle after reset release).
- REQ: `imem_req=1`, `imem_addr=pc`. On accept: latch `pc` as pending address, `pc <= pc+4`, →WAIT. No accept: stay.
- WAIT: on `imem_rvalid`: if `drop`, discard data, clear `drop`, →REQ; else load buffer (`instr=imem_rdata`, `instr_pc`=pending address), →HOLD.
- HOLD: `instr_valid=1`. On consume →REQ.
- Redirect = `branch_taken || jump`. Branch has priority when both are high.
- Branch target = `redirect_pc + 4 + imm_sl2`, modulo 2^n (negative offsets are two's complement).
- Jump target = {(`redirect_pc`+4)[n-1:28], `jump_index`, 2'b00}.
- Redirect effects, by state:
  - Any state: `pc <= target`; this overrides the +4 update.
  - REQ: a request accepted in the same cycle →WAIT with `drop=1`. Otherwise stay in REQ with the new `pc`.
  - WAIT: `drop <= 1`. The response is discarded.
  - HOLD: buffer invalidated, `instr_valid` low next cycle, →REQ. A consume in the same cycle is still honoured for the current `instr`.
  - IDLE: only `pc` is updated.
- PC arithmetic wraps modulo 2^n. No alignment check; the low two bits pass through unchanged.

## Timing
- Reset (`rstn=0` at rising edge): `pc=RESET_PC`, state IDLE, `drop=0`, `imem_req=0`, `imem_addr=RESET_PC`, `instr_valid=0`, `instr=0`, `instr_pc=0`.
- Reset mid-operation aborts everything. A later `imem_rvalid` for a pre-reset request must be ignored by tracking it with `drop`: if reset occurs in WAIT, `drop` stays 1 through reset.
- `imem_req` and `instr_valid` are decoded from state registers, never combinationally from inputs.
- Best-case latency, reset release at edge 0:
  - `imem_req` high after edge 1.
  - Accept at edge 2.
  - `imem_rvalid` in the cycle before edge 3.
  - `instr_valid` high after edge 3.
- Throughput: one instruction per 3 cycles with zero-wait memory and `instr_ready=1`.
- Redirect takes effect at the next edge. The first request to the target is issued the cycle after redirect, or after the dropped response arrives.

## Test plan
- Reset, zero-wait memory, `instr_ready=1`: fetch addresses are 0x00, 0x04, 0x08. `instr_pc` matches each address, and `instr` equals the memory word.
- Branch in HOLD with `redirect_pc=0x10`, `imm_sl2=0x20`: buffer invalidated, next `imem_addr=0x34`. Then `imm_sl2=0xFFFFFFF0` with `redirect_pc=0x10`: next `imem_addr=0x04`.
- Jump with `redirect_pc=0x1000_0000`, `jump_index=0x0000100`: next `imem_addr=0x1000_0400`. Assert `branch_taken` simultaneously: the branch target wins.
- Redirect while in WAIT with a 3-cycle memory delay: the old response is never presented on `instr`, and the next accepted `imem_addr` equals the target.
- `RESET_PC=0xFFFFFFFC`: second fetch address is 0x00000000 (wrap).
- `instr_ready=0` for 5 cycles in HOLD: `instr`/`instr_pc` stable and no new `imem_req`. Assert `rstn=0` in WAIT, then return a stale `imem_rvalid`: it is ignored, and the first post-reset fetch is at `RESET_PC`.
